escalonador_quantum: RTL

- Parametrised round-robin preemptive program scheduler for the multi-program processor.
- Generalises the existing single-pair program-switch logic (defquantum / changeProgram / spc / lpc) to NUM_PROG program slots.
- Adds a programmable quantum, voluntary yield and automatic completion detection.
- Owns the saved-PC table; sits between the UC strobes and the PC register, stalling the processor during context switches.

---
 rtl/escalonador_quantum.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/escalonador_quantum.sv
// Round-robin preemptive scheduler for NUM_PROG program slots.
// Owns the saved-PC table, counts retired instructions against a programmable
// quantum and sequences SAVE -> SELECT -> LOAD context switches, stalling the
// processor (switching=1) while a switch is in flight.
module escalonador_quantum #(
   parameter int NUM_PROG        = 4,
   parameter int PC_WIDTH        = 32,
   parameter int QUANTUM_WIDTH   = 16,
   parameter int DEFAULT_QUANTUM = 100,
   localparam int ID_WIDTH       = $clog2(NUM_PROG)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     reg_valid,
   input  logic [ID_WIDTH-1:0]      reg_id,
   input  logic [PC_WIDTH-1:0]      reg_pc,
   input  logic                     start,
   input  logic                     instr_retired,
   input  logic                     stop,
   input  logic                     def_quantum,
   input  logic [QUANTUM_WIDTH-1:0] quantum_in,
   input  logic                     next_program,
   input  logic                     end_program,
   input  logic [PC_WIDTH-1:0]      pc_current,
   output logic                     load_pc,
   output logic [PC_WIDTH-1:0]      pc_out,
   output logic [ID_WIDTH-1:0]      current_id,
   output logic                     switching,
   output logic [NUM_PROG-1:0]      ready_mask,
   output logic                     all_done
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_RUN, ST_SAVE, ST_SELECT, ST_LOAD, ST_DONE
   } state_t;

   localparam logic [QUANTUM_WIDTH-1:0] Q_ONE = QUANTUM_WIDTH'(1);

   state_t                     state_q, state_d;
   logic [ID_WIDTH-1:0]        current_id_q, current_id_d;
   logic [NUM_PROG-1:0]        ready_q, ready_d;
   logic [PC_WIDTH-1:0]        pc_out_q, pc_out_d;
   logic [QUANTUM_WIDTH-1:0]   quantum_q, quantum_d;
   logic [QUANTUM_WIDTH-1:0]   counter_q, counter_d;
   logic [PC_WIDTH-1:0]        tbl_q [NUM_PROG];
   logic [PC_WIDTH-1:0]        tbl_d [NUM_PROG];

   logic                       sel_found;
   logic [ID_WIDTH-1:0]        sel_id;
   logic                       retire_ok;
   logic                       expiry;

   // Round-robin search: lowest offset from current_id+1 wins, current_id last.
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_id    = current_id_q;
      for (int k = NUM_PROG; k >= 1; k--) begin
         idx = (int'(current_id_q) + k) % NUM_PROG;
         if (ready_q[ID_WIDTH'(idx)]) begin
            sel_found = 1'b1;
            sel_id    = ID_WIDTH'(idx);
         end
      end
   end

   // Next-state, counter, quantum and table update logic.
   always_comb begin
      state_d      = state_q;
      current_id_d = current_id_q;
      ready_d      = ready_q;
      pc_out_d     = pc_out_q;
      quantum_d    = quantum_q;
      counter_d    = counter_q;
      tbl_d        = tbl_q;
      retire_ok    = instr_retired & ~stop;
      expiry       = retire_ok & (counter_q >= (quantum_q - Q_ONE));

      // A zero quantum would never let a program run; such writes are dropped.
      if (def_quantum && (quantum_in != '0)) begin
         quantum_d = quantum_in;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (reg_valid && (int'(reg_id) < NUM_PROG)) begin
               tbl_d[reg_id]   = reg_pc;
               ready_d[reg_id] = 1'b1;
            end
            if (start && (ready_q != '0)) begin
               state_d = ST_SELECT;
            end
         end
         ST_RUN: begin
            if (retire_ok && (counter_q != '1)) begin
               counter_d = counter_q + Q_ONE;
            end
            // A finished program has nothing worth saving, so it skips SAVE.
            if (end_program) begin
               ready_d[current_id_q] = 1'b0;
               state_d               = ST_SELECT;
            end else if (next_program || expiry) begin
               state_d = ST_SAVE;
            end
         end
         ST_SAVE: begin
            tbl_d[current_id_q] = pc_current;
            state_d             = ST_SELECT;
         end
         ST_SELECT: begin
            if (sel_found) begin
               current_id_d = sel_id;
               pc_out_d     = tbl_q[sel_id];
               state_d      = ST_LOAD;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_LOAD: begin
            counter_d = '0;
            state_d   = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any switch in progress immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         current_id_q <= '0;
         ready_q      <= '0;
         pc_out_q     <= '0;
         quantum_q    <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
         counter_q    <= '0;
         for (int i = 0; i < NUM_PROG; i++) begin
            tbl_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         current_id_q <= current_id_d;
         ready_q      <= ready_d;
         pc_out_q     <= pc_out_d;
         quantum_q    <= quantum_d;
         counter_q    <= counter_d;
         tbl_q        <= tbl_d;
      end
   end

   assign load_pc    = (state_q == ST_LOAD);
   assign switching  = (state_q == ST_SAVE) || (state_q == ST_SELECT) || (state_q == ST_LOAD);
   assign all_done   = (state_q == ST_DONE);
   assign pc_out     = pc_out_q;
   assign current_id = current_id_q;
   assign ready_mask = ready_q;

endmodule
